ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Iterative multiply/divide unit in the EX stage, fed directly by the ID/EX pipeline register outputs (ALU op, Rdata1/Rdata2 after forwarding). It executes MULT/MULTU/DIV/DIVU over 32 iteration cycles and owns the architectural HI/LO registers. It serves MFHI/MFLO/MTHI/MTLO in a single cycle. While a long operation is running it holds the front of the pipeline through `Stall`.

## Interface
Parameters:
- `XLEN`, 32: operand and HI/LO width.
- `ITER`, 32: iteration cycles per long op; must equal `XLEN`.

Ports. Reset is `Reset`, synchronous, active-high, on clock `Clk`.
- `Clk` in 1: clock; all state updates on posedge.
- `Reset` in 1: synchronous, active-high.
- `Valid` in 1: the EX-stage instruction is live (not a bubble).
- `ALUOp` in 5: op code from ID/EX.
- `A` in XLEN: forwarded rs value; dividend or multiplicand.
- `B` in XLEN: forwarded rt value; divisor or multiplier.
- `Flush` in 1: abort the in-flight op (branch/exception squash).
- `Stall` out 1: hold PC, IF/ID and ID/EX.
- `Busy` out 1: state is BUSY.
- `Result` out XLEN: HI or LO for MFHI/MFLO; otherwise 0.
- `ResultValid` out 1: `Result` is valid this cycle.
- `Hi` out XLEN: HI register.
- `Lo` out XLEN: LO register.

## Operation
Op codes are fixed at these values:
- 20 MULT
- 21 MULTU
- 22 DIV
- 23 DIVU
- 24 MFHI
- 25 MFLO
- 26 MTHI
- 27 MTLO

Any other `ALUOp` is ignored by this unit.

State machine: IDLE, BUSY, DONE.
- IDLE, `Valid` and a long op (20–23): latch |A|, |B| (signed ops) or A, B (unsigned ops). Record the result signs. Counter = ITER-1. Go to BUSY.
- BUSY: one shift-add step (multiply) or one restoring shift-subtract step (divide) per cycle. Counter decrements.
- BUSY at counter==0: write the sign-corrected result into HI/LO at this edge. Go to DONE.
- DONE: for one cycle only; long-op starts are ignored. Go to IDLE.
- MTHI/MTLO in IDLE with `Valid`: HI or LO <= A at the edge. No stall.
- MFHI/MFLO in IDLE with `Valid`: `Result` = HI or LO combinationally; `ResultValid`=1.

Results:
- Multiply: {HI,LO} = 64-bit product. Signed: negate the product if the operand signs differ.
- Divide: LO = quotient, HI = remainder.
- Signed divide: quotient is negated if the signs differ; remainder takes the dividend's sign.
- Divide by zero: LO = 32'hFFFF_FFFF, HI = A. The op still takes the full ITER cycles.
- DIV of 32'h8000_0000 by 32'hFFFF_FFFF: LO = 32'h8000_0000, HI = 0.

## Timing
Stall:
- `Stall` = (IDLE & `Valid` & long op) | BUSY. It is combinational and forced to 0 while `Reset` is high.
- `Stall`=0 in DONE, so the op leaves EX that cycle.
- EX occupancy for a long op: 1 (IDLE) + 32 (BUSY) + 1 (DONE) = 34 cycles.

HI/LO visibility:
- HI/LO are updated at the BUSY→DONE edge.
- An MFHI/MFLO entering EX right after DONE reads the new value.

Flush:
- `Flush` in any state: go to IDLE at the next edge. HI/LO are unchanged and the partial result is discarded.
- `Flush` has priority over completion in the same cycle.
- `Flush` with an IDLE start: no start occurs.

Reset:
- `Reset` has priority over `Flush` and forces state IDLE.
- Reset values: HI=0, LO=0, counter=0, `Busy`=0, `Stall`=0, `Result`=0, `ResultValid`=0.
- Reset mid-BUSY aborts the op.

Other rules:
- MTHI/MTLO and MF ops are never presented during BUSY, because the pipeline is stalled. The unit ignores them if they are.

## Structure
- Package `md_pkg`: op code localparams (20–27), the state typedef {IDLE, BUSY, DONE}, and the divide-by-zero LO constant.
- Sub-module `md_iter_core`: 64-bit accumulator/remainder datapath, one step per enable, with a mode input (mul/div). FSM, sign handling, and HI/LO stay in `ex_muldiv_unit`.

## Test plan
- MULTU A=32'hFFFF_FFFF, B=2 → `Stall` high for 33 cycles; then HI=1, LO=32'hFFFF_FFFE; `Stall` low in DONE.
- MULT A=-3, B=7 → HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB. DIV A=-7, B=2 → LO=-3, HI=-1.
- DIVU A=100, B=0 → LO=32'hFFFF_FFFF, HI=100 after 34 EX cycles. DIV 32'h8000_0000 / -1 → LO=32'h8000_0000, HI=0.
- MTLO A=5, then MULTU 3×4, then MFLO the cycle after DONE → `Result`=12 with `ResultValid`=1. MFHI before the MULT → 0.
- `Flush` at BUSY cycle 10 of DIVU 9/3 → IDLE next cycle, `Stall`=0, HI/LO keep their prior values.
- `Reset` at BUSY cycle 5 → all outputs 0 at the next edge. A new MULTU 2×3 afterwards → LO=6.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
//   - ALU op codes handled by ex_muldiv_unit (20..27)
//   - FSM state type
//   - LO value written on divide by zero
package md_pkg;

    localparam logic [4:0] OP_MULT  = 5'd20;
    localparam logic [4:0] OP_MULTU = 5'd21;
    localparam logic [4:0] OP_DIV   = 5'd22;
    localparam logic [4:0] OP_DIVU  = 5'd23;
    localparam logic [4:0] OP_MFHI  = 5'd24;
    localparam logic [4:0] OP_MFLO  = 5'd25;
    localparam logic [4:0] OP_MTHI  = 5'd26;
    localparam logic [4:0] OP_MTLO  = 5'd27;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_t;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/md_iter_core.sv
// Iterative multiply/divide datapath: one shift-add (multiply) or one
// restoring shift-subtract (divide) step per i_step. Works on unsigned
// magnitudes only; signs are handled by the parent.
//   Clk, Reset     : clock, synchronous active-high reset
//   i_load         : load i_lo_init into the low half, clear the high half, latch i_opd
//   i_step         : perform one iteration
//   i_div          : 1 = divide step, 0 = multiply step
//   i_lo_init      : multiplier (mul) or dividend (div)
//   i_opd          : multiplicand (mul) or divisor (div)
//   o_step_hi_c/lo_c : value the registers take after the current step
//                    (lets the parent commit the last step at the same edge)
module md_iter_core #(
    parameter int unsigned XLEN = 32
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_div,
    input  logic [XLEN-1:0] i_lo_init,
    input  logic [XLEN-1:0] i_opd,
    output logic [XLEN-1:0] o_step_hi_c,
    output logic [XLEN-1:0] o_step_lo_c
);

    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_opd;

    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_trial;

    // Next-step value for both modes
    always_comb begin
        w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : '0);
        w_rem_sh = {r_hi, r_lo[XLEN-1]};
        w_trial  = w_rem_sh - {1'b0, r_opd};
        if (i_div) begin
            // Trial subtraction; a clear top bit means the divisor fits
            if (!w_trial[XLEN]) begin
                o_step_hi_c = w_trial[XLEN-1:0];
                o_step_lo_c = {r_lo[XLEN-2:0], 1'b1};
            end else begin
                o_step_hi_c = w_rem_sh[XLEN-1:0];
                o_step_lo_c = {r_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            o_step_hi_c = w_sum[XLEN:1];
            o_step_lo_c = {w_sum[0], r_lo[XLEN-1:1]};
        end
    end

    // Accumulator / remainder registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_opd <= '0;
        end else if (i_load) begin
            r_hi  <= '0;
            r_lo  <= i_lo_init;
            r_opd <= i_opd;
        end else if (i_step) begin
            r_hi  <= o_step_hi_c;
            r_lo  <= o_step_lo_c;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit owning the HI/LO registers.
// Long ops (MULT/MULTU/DIV/DIVU) run for ITER cycles while Stall holds the
// front of the pipeline; MFHI/MFLO/MTHI/MTLO complete in a single cycle.
//   Clk, Reset   : clock, synchronous active-high reset
//   Valid        : EX instruction is live
//   ALUOp        : op code from ID/EX
//   A, B         : forwarded rs / rt values
//   Flush        : squash the in-flight op
//   Stall        : hold PC, IF/ID, ID/EX (combinational)
//   Busy         : iteration in progress
//   Result       : HI/LO for MFHI/MFLO, else 0 (combinational)
//   ResultValid  : Result is valid this cycle
//   Hi, Lo       : architectural HI/LO
module ex_muldiv_unit
    import md_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ITER = 32
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Valid,
    input  logic [4:0]      ALUOp,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            Flush,
    output logic            Stall,
    output logic            Busy,
    output logic [XLEN-1:0] Result,
    output logic            ResultValid,
    output logic [XLEN-1:0] Hi,
    output logic [XLEN-1:0] Lo
);

    localparam int unsigned CW = $clog2(ITER);

    md_state_t       r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_is_div;
    logic            r_neg_q;   // negate quotient / product
    logic            r_neg_r;   // negate remainder
    logic            r_dvz;     // divide by zero
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;

    logic            w_long;
    logic            w_div_op;
    logic            w_signed_op;
    logic            w_start;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic [XLEN-1:0] w_step_hi;
    logic [XLEN-1:0] w_step_lo;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0] w_quo;
    logic [XLEN-1:0] w_rem;

    assign w_long      = (ALUOp >= OP_MULT) && (ALUOp <= OP_DIVU);
    assign w_div_op    = (ALUOp == OP_DIV)  || (ALUOp == OP_DIVU);
    assign w_signed_op = (ALUOp == OP_MULT) || (ALUOp == OP_DIV);
    assign w_start     = (r_state == IDLE) && Valid && w_long;

    assign w_abs_a = (w_signed_op && A[XLEN-1]) ? -A : A;
    assign w_abs_b = (w_signed_op && B[XLEN-1]) ? -B : B;

    md_iter_core #(.XLEN(XLEN)) u_core (
        .Clk         (Clk),
        .Reset       (Reset),
        .i_load      (w_start && !Flush),
        .i_step      (r_state == BUSY),
        .i_div       (r_state == BUSY ? r_is_div : w_div_op),
        .i_lo_init   (w_div_op ? w_abs_a : w_abs_b),
        .i_opd       (w_div_op ? w_abs_b : w_abs_a),
        .o_step_hi_c (w_step_hi),
        .o_step_lo_c (w_step_lo)
    );

    // Sign correction of the final step's value
    assign w_prod = r_neg_q ? -{w_step_hi, w_step_lo} : {w_step_hi, w_step_lo};
    assign w_quo  = r_dvz ? DIV0_LO : (r_neg_q ? -w_step_lo : w_step_lo);
    assign w_rem  = r_neg_r ? -w_step_hi : w_step_hi;

    // Control FSM and HI/LO
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dvz    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (Flush) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state  <= BUSY;
                        r_cnt    <= CW'(ITER - 1);
                        r_is_div <= w_div_op;
                        r_neg_q  <= w_signed_op && (A[XLEN-1] ^ B[XLEN-1]);
                        r_neg_r  <= w_signed_op && A[XLEN-1];
                        r_dvz    <= w_div_op && (B == '0);
                    end else if (Valid && ALUOp == OP_MTHI) begin
                        r_hi <= A;
                    end else if (Valid && ALUOp == OP_MTLO) begin
                        r_lo <= A;
                    end
                end
                BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                        if (r_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end else begin
                            r_hi <= w_prod[2*XLEN-1:XLEN];
                            r_lo <= w_prod[XLEN-1:0];
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        Stall       = 1'b0;
        ResultValid = 1'b0;
        Result      = '0;
        if (!Reset) begin
            Stall = w_start || (r_state == BUSY);
            if ((r_state == IDLE) && Valid && (ALUOp == OP_MFHI)) begin
                Result      = r_hi;
                ResultValid = 1'b1;
            end else if ((r_state == IDLE) && Valid && (ALUOp == OP_MFLO)) begin
                Result      = r_lo;
                ResultValid = 1'b1;
            end
        end
    end

    assign Busy = (r_state == BUSY);
    assign Hi   = r_hi;
    assign Lo   = r_lo;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed testbench for ex_muldiv_unit with hand-computed expected values.
module tb_ex_muldiv_unit;
    import md_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Valid;
    logic [4:0]  ALUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Flush;
    logic        Stall;
    logic        Busy;
    logic [31:0] Result;
    logic        ResultValid;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    ex_muldiv_unit dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Valid       (Valid),
        .ALUOp       (ALUOp),
        .A           (A),
        .B           (B),
        .Flush       (Flush),
        .Stall       (Stall),
        .Busy        (Busy),
        .Result      (Result),
        .ResultValid (ResultValid),
        .Hi          (Hi),
        .Lo          (Lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        Valid = v;
        ALUOp = op;
        A     = a;
        B     = b;
    endtask

    // Issue a long op, hold it while stalled, return in IDLE after DONE
    task automatic run_long(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
        int n = 0;
        drive(1'b1, op, a, b);
        #1;
        while (Stall && n < 100) begin
            n++;
            tick();
        end
        chk({tag, "_stall_cycles"}, 64'(n), 64'd33);
        chk({tag, "_done_busy"}, 64'(Busy), 64'd0);
        chk({tag, "_hi"}, 64'(Hi), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(Lo), 64'(exp_lo));
        drive(1'b0, 5'd0, '0, '0);
        tick();
    endtask

    // Start a long op and stop in BUSY cycle k
    task automatic start_to(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int k);
        drive(1'b1, op, a, b);
        for (int i = 0; i < k; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        Flush = 1'b0;
        drive(1'b1, OP_MULT, 32'd5, 32'd6);
        tick();
        tick();
        chk("rst_stall", 64'(Stall), 64'd0);
        chk("rst_busy",  64'(Busy),  64'd0);
        chk("rst_hi",    64'(Hi),    64'd0);
        chk("rst_lo",    64'(Lo),    64'd0);
        drive(1'b1, OP_MFHI, '0, '0);
        #1;
        chk("rst_rv",    64'(ResultValid), 64'd0);
        Reset = 1'b0;
        #1;

        // MFHI before any multiply reads reset HI
        chk("mfhi0_res", 64'(Result), 64'd0);
        chk("mfhi0_rv",  64'(ResultValid), 64'd1);
        drive(1'b0, 5'd0, '0, '0);
        tick();

        run_long(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, "multu");
        run_long(OP_MULT,  32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult");
        run_long(OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
        run_long(OP_DIVU,  32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, "divu0");
        run_long(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "divovf");
        run_long(OP_DIV,   32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div0neg");

        // MTLO, then MULTU, then MFLO right after DONE
        drive(1'b1, OP_MTLO, 32'd5, '0);
        #1;
        chk("mtlo_stall", 64'(Stall), 64'd0);
        chk("mtlo_res",   64'(Result), 64'd0);
        tick();
        chk("mtlo_lo", 64'(Lo), 64'd5);
        run_long(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, "mul34");
        drive(1'b1, OP_MFLO, '0, '0);
        #1;
        chk("mflo_res", 64'(Result), 64'd12);
        chk("mflo_rv",  64'(ResultValid), 64'd1);

        // Flush in BUSY cycle 10 of DIVU 9/3
        drive(1'b1, OP_MTHI, 32'hAA, '0);
        tick();
        drive(1'b1, OP_MTLO, 32'hBB, '0);
        tick();
        start_to(OP_DIVU, 32'd9, 32'd3, 10);
        chk("fl_busy_pre", 64'(Busy), 64'd1);
        Flush = 1'b1;
        drive(1'b0, 5'd0, '0, '0);
        tick();
        Flush = 1'b0;
        #1;
        chk("fl_busy",  64'(Busy),  64'd0);
        chk("fl_stall", 64'(Stall), 64'd0);
        for (int i = 0; i < 40; i++) tick();
        chk("fl_hi", 64'(Hi), 64'hAA);
        chk("fl_lo", 64'(Lo), 64'hBB);

        // Flush together with an IDLE start: no start
        drive(1'b1, OP_DIVU, 32'd9, 32'd3);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        drive(1'b0, 5'd0, '0, '0);
        #1;
        chk("fl_idle_busy", 64'(Busy), 64'd0);

        // Reset in BUSY cycle 5
        start_to(OP_MULTU, 32'd7, 32'd9, 5);
        Reset = 1'b1;
        drive(1'b0, 5'd0, '0, '0);
        tick();
        chk("rb_hi",    64'(Hi),    64'd0);
        chk("rb_lo",    64'(Lo),    64'd0);
        chk("rb_busy",  64'(Busy),  64'd0);
        chk("rb_stall", 64'(Stall), 64'd0);
        chk("rb_res",   64'(Result), 64'd0);
        chk("rb_rv",    64'(ResultValid), 64'd0);
        Reset = 1'b0;
        tick();
        run_long(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, "mul23");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
